axil_reg_target: RTL and testbench
==================================

# axil_reg_target

AXI4-Lite slave register target terminating the AXI4-Lite master control plane that the OPED endpoint drives from host PCIe BAR accesses. It decodes a small address window into NREG 32-bit read/write registers, supports byte-strobed writes and independent write-address and write-data acceptance, and returns OKAY or SLVERR responses. Register contents and per-register write strobes are exported to the worker/control logic on the ACLK domain.

## Interface
- NREG, 16: number of implemented 32-bit registers, 1..64.
- ADDR_BITS, 8: decoded window width in bytes.
  - Requires 2^(ADDR_BITS-2) ≥ NREG.
  - Upper address bits [31:ADDR_BITS] are ignored, so the window aliases.
- RESET_VAL, 32'h0: reset value of every register.
- ACLK in 1: sole clock, rising edge.
- ARESET in 1: asynchronous, active-high reset.
- S_AXI_AWADDR in 32: write address; byte address, bits [1:0] ignored.
- S_AXI_AWPROT in 3: ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write-address handshake.
- S_AXI_WDATA in 32: write data.
- S_AXI_WSTRB in 4: write byte enables; bit i enables byte lane i.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write-data handshake.
- S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response.
- S_AXI_ARADDR in 32: read address.
- S_AXI_ARPROT in 3: ignored.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read-address handshake.
- S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data.
- REG_OUT out NREG*32: register contents; register k occupies bits [32k+31:32k].
- WR_PULSE out NREG: one-cycle strobe, bit k set when register k is written.

## Operation
- Decoded word index is addr[ADDR_BITS-1:2].
  - Index < NREG: implemented register.
  - Index ≥ NREG: unmapped.
- Write path state: aw_full (latched AW index), w_full (latched WDATA/WSTRB), BVALID.
  - S_AXI_AWREADY = !ARESET & !aw_full & !BVALID.
  - S_AXI_WREADY = !ARESET & !w_full & !BVALID.
  - AW and W are accepted in either order or in the same cycle. The first one accepted is held until its partner arrives.
- Commit occurs on an edge where aw_full & w_full & !BVALID.
  - For each lane i with WSTRB[i]=1, byte i of the register is updated. Lanes with WSTRB[i]=0 are unchanged.
  - WSTRB=0 produces no data change but still responds and still pulses WR_PULSE.
  - Unmapped index: no register changes, no WR_PULSE.
  - BRESP: 2'b00 when mapped, 2'b10 (SLVERR) when unmapped.
  - The same edge clears aw_full and w_full, sets BVALID, and sets WR_PULSE[k] for exactly one cycle.
- BVALID clears on the edge where BVALID & BREADY.
  - BRESP holds stable while BVALID=1.
  - No new AW or W is accepted while BVALID=1, so at most one write is outstanding.
- Read path: S_AXI_ARREADY = !ARESET & !RVALID.
  - On AR handshake, RDATA gets the register value as it was before that edge, and RVALID goes to 1.
  - Mapped read: RRESP=2'b00.
  - Unmapped read: RDATA=32'h0, RRESP=2'b10.
- RVALID clears on RVALID & RREADY. RDATA and RRESP hold stable while RVALID=1.
- Read and write paths are fully independent. A read concurrent with a commit to the same register returns the pre-commit value.

## Timing
- Reset (ARESET=1, asynchronous):
  - All registers = RESET_VAL.
  - aw_full = w_full = 0.
  - BVALID = RVALID = 0, BRESP = RRESP = 0, RDATA = 0, WR_PULSE = 0.
  - AWREADY = WREADY = ARREADY = 0.
- First cycle after ARESET deasserts: AWREADY = WREADY = ARREADY = 1.
- Reset asserted mid-transaction: latched AW/W, pending B and pending R are all discarded. No partial register update occurs.
- Write, AW and W handshaken on the same edge E:
  - Commit at E+1; BVALID, REG_OUT update and WR_PULSE are visible after E+1.
  - Best-case write throughput is one write per 3 cycles with BREADY tied high.
- Write, AW at edge E and W at a later edge F: commit at F+1. The symmetric case (W first) behaves the same way.
- Read: AR handshake at edge E; RVALID=1 after E. With RREADY tied high the next AR is accepted at E+2.
- Backpressure: BVALID and RVALID hold for any number of cycles until their READY is sampled high.

## Test plan
- Reset values: hold ARESET high, write traffic driven → no READY asserted. Release, read index 0 → RDATA=RESET_VAL, RRESP=0, RVALID seen on the cycle after the AR handshake.
- Same-cycle full write: AW=0x08 and W=0xCAFEBABE/strb 0xF on one edge.
  - Commit one edge later: REG_OUT[95:64]=0xCAFEBABE, WR_PULSE=0x0004 for one cycle, BRESP=0.
  - Hold BREADY low 5 cycles → BVALID stays 1 and AWREADY stays 0.
- Out-of-order and partial write: W=0x11223344/strb 4'b0101 three cycles before AW=0x0C, with reg3=0xAABBCCDD → reg3=0xAA22CC44 one edge after the AW handshake.
- Unmapped and alias, NREG=16:
  - Write 0x40 → BRESP=2'b10, no WR_PULSE, no register change.
  - Read 0x40 → RDATA=0, RRESP=2'b10.
  - Read 0x1000_0008 → reg2 value, RRESP=0.
- Read/write collision: read reg5 on the same edge reg5 commits 0x5 over 0x0 → RDATA=0x0; the next read returns 0x5.
- Reset mid-write: AW accepted, assert ARESET before W, release, send W only → no commit and no BVALID until a new AW arrives.

Source files
------------

// File: rtl/axil_reg_target.sv
// AXI4-Lite register target: NREG byte-strobed 32-bit registers exported to control logic.
// Latency: write commits one edge after both AW and W are held; read data one edge after AR.
// Backpressure: AW/W stall while a B response is pending, AR stalls while R is pending.
module axil_reg_target #(
    parameter int          NREG      = 16,
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          S_AXI_AWADDR,
    input  logic [2:0]           S_AXI_AWPROT,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [31:0]          S_AXI_WDATA,
    input  logic [3:0]           S_AXI_WSTRB,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [31:0]          S_AXI_ARADDR,
    input  logic [2:0]           S_AXI_ARPROT,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [31:0]          S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY,
    output logic [NREG*32-1:0]   REG_OUT,
    output logic [NREG-1:0]      WR_PULSE
);
    localparam int            IW       = ADDR_BITS - 2;
    localparam logic [IW:0]   NREG_LIM = (IW+1)'(NREG);
    localparam logic [1:0]    OKAY     = 2'b00;
    localparam logic [1:0]    SLVERR   = 2'b10;

    logic          aw_full, w_full, bvalid, rvalid;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [31:0]   w_dat, rdata, rd_val;
    logic [3:0]    w_strb;
    logic [1:0]    bresp, rresp;
    logic          aw_hs, w_hs, ar_hs, commit, aw_mapped, ar_mapped;
    logic [NREG*32-1:0] reg_flat;

    assign S_AXI_AWREADY = !ARESET && !aw_full && !bvalid;
    assign S_AXI_WREADY  = !ARESET && !w_full && !bvalid;
    assign S_AXI_ARREADY = !ARESET && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign REG_OUT       = reg_flat;

    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit    = aw_full && w_full && !bvalid;
    assign ar_idx    = S_AXI_ARADDR[ADDR_BITS-1:2];
    assign aw_mapped = {1'b0, aw_idx} < NREG_LIM;
    assign ar_mapped = {1'b0, ar_idx} < NREG_LIM;

    // Upper address bits alias the window; byte offset and PROT carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[31:ADDR_BITS],
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:ADDR_BITS], S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_dat   <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[ADDR_BITS-1:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_dat  <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= aw_mapped ? OKAY : SLVERR;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        logic [31:0] r;
        logic        pulse;
        logic        hit;

        // An index below NREG is mapped by construction, so no separate range check.
        assign hit = commit && (aw_idx == IW'(k));

        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                r     <= RESET_VAL;
                pulse <= 1'b0;
            end else begin
                pulse <= hit;
                if (hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b]) r[8*b +: 8] <= w_dat[8*b +: 8];
                    end
                end
            end
        end

        assign reg_flat[32*k +: 32] = r;
        assign WR_PULSE[k]          = pulse;
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NREG; k++) begin
            if (ar_idx == IW'(k)) rd_val = reg_flat[32*k +: 32];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= ar_mapped ? OKAY : SLVERR;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_reg_target.sv
// Directed bench for axil_reg_target: reset, write ordering, strobes, unmapped/alias, collisions.
module tb_axil_reg_target;
    localparam int NREG = 16;

    logic               ACLK = 1'b0;
    logic               ARESET;
    logic [31:0]        S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [2:0]         S_AXI_AWPROT, S_AXI_ARPROT;
    logic               S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [3:0]         S_AXI_WSTRB;
    logic [1:0]         S_AXI_BRESP, S_AXI_RRESP;
    logic               S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic               S_AXI_RVALID, S_AXI_RREADY;
    logic [NREG*32-1:0] REG_OUT;
    logic [NREG-1:0]    WR_PULSE;

    int total = 0;
    int passed = 0;
    int fails = 0;

    axil_reg_target #(.NREG(NREG), .ADDR_BITS(8), .RESET_VAL(32'h0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rv(input int k);
        return REG_OUT[32*k +: 32];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp, output logic [NREG-1:0] pulse);
        bit aw_done = 0;
        bit w_done = 0;
        bit got = 0;
        resp  = 2'bxx;
        pulse = 'x;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            bit aw_hs;
            bit w_hs;
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin S_AXI_WVALID = 1'b0;  w_done = 1;  end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (S_AXI_BVALID) begin
                resp = S_AXI_BRESP; pulse = WR_PULSE; got = 1;
            end
        end
        if (!got) chk("wr_bvalid_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit done = 0;
        d = 'x; resp = 2'bxx;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            bit hs;
            hs = S_AXI_ARREADY;
            tick();
            if (hs) done = 1;
        end
        S_AXI_ARVALID = 1'b0;
        if (!done) chk("rd_ar_timeout", 64'd0, 64'd1);
        chk("rd_rvalid_after_ar", 64'(S_AXI_RVALID), 64'd1);
        d = S_AXI_RDATA; resp = S_AXI_RRESP;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        logic [NREG-1:0] pulse;
        logic [NREG*32-1:0] snap;

        // Reset held with traffic present: nothing may be accepted.
        ARESET = 1'b1;
        S_AXI_AWPROT = 3'b0; S_AXI_ARPROT = 3'b0;
        S_AXI_AWADDR = 32'h4; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h0; S_AXI_ARVALID = 1'b1;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick(); tick(); tick();
        chk("rst_ready", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd0);
        chk("rst_valid", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'd0);
        chk("rst_resp_data", 64'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 64'd0);
        chk("rst_pulse", 64'(WR_PULSE), 64'd0);
        chk("rst_regs_or", 64'(|REG_OUT), 64'd0);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        ARESET = 1'b0;
        #1;
        chk("post_rst_ready", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h7);
        rd(32'h0, d, resp);
        chk("rd0_data", 64'(d), 64'h0);
        chk("rd0_resp", 64'(resp), 64'd0);

        // Same-edge AW and W with B backpressure.
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hCAFE_BABE; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("same_pre_bvalid", 64'(S_AXI_BVALID), 64'd0);
        chk("same_pre_reg2", 64'(rv(2)), 64'h0);
        tick();
        chk("same_bvalid", 64'(S_AXI_BVALID), 64'd1);
        chk("same_bresp", 64'(S_AXI_BRESP), 64'd0);
        chk("same_reg2", 64'(rv(2)), 64'hCAFE_BABE);
        chk("same_pulse", 64'(WR_PULSE), 64'h0004);
        tick();
        chk("same_pulse_clear", 64'(WR_PULSE), 64'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_bvalid_held", 64'(S_AXI_BVALID), 64'd1);
        chk("bp_awready_low", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        chk("bp_bvalid_clear", 64'(S_AXI_BVALID), 64'd0);
        chk("bp_awready_back", 64'(S_AXI_AWREADY), 64'd1);

        // W three cycles ahead of AW, partial strobes.
        wr(32'h0C, 32'hAABB_CCDD, 4'hF, resp, pulse);
        chk("reg3_preset", 64'(rv(3)), 64'hAABB_CCDD);
        S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        tick(); tick(); tick();
        chk("wfirst_no_commit", 64'({S_AXI_BVALID, rv(3)}), 64'h0_AABB_CCDD);
        chk("wfirst_wready_low", 64'(S_AXI_WREADY), 64'd0);
        S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("wfirst_reg3_pre", 64'(rv(3)), 64'hAABB_CCDD);
        tick();
        chk("wfirst_reg3", 64'(rv(3)), 64'hAA22_CC44);
        chk("wfirst_pulse", 64'(WR_PULSE), 64'h0008);
        tick();

        // Zero strobe: pulses and responds, no data change.
        wr(32'h08, 32'h1234_5678, 4'h0, resp, pulse);
        chk("strb0_resp", 64'(resp), 64'd0);
        chk("strb0_pulse", 64'(pulse), 64'h0004);
        chk("strb0_reg2", 64'(rv(2)), 64'hCAFE_BABE);

        // Unmapped index and aliased upper bits.
        snap = REG_OUT;
        wr(32'h40, 32'hFFFF_FFFF, 4'hF, resp, pulse);
        chk("unmap_bresp", 64'(resp), 64'd2);
        chk("unmap_pulse", 64'(pulse), 64'h0);
        chk("unmap_regs", 64'(REG_OUT == snap), 64'd1);
        rd(32'h40, d, resp);
        chk("unmap_rdata", 64'(d), 64'h0);
        chk("unmap_rresp", 64'(resp), 64'd2);
        rd(32'h1000_0008, d, resp);
        chk("alias_rdata", 64'(d), 64'hCAFE_BABE);
        chk("alias_rresp", 64'(resp), 64'd0);

        // Read of reg5 on its commit edge returns the old value.
        S_AXI_AWADDR = 32'h14; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = 32'h14; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        chk("coll_rvalid", 64'(S_AXI_RVALID), 64'd1);
        chk("coll_rdata_old", 64'(S_AXI_RDATA), 64'h0);
        chk("coll_reg5", 64'(rv(5)), 64'h5);
        tick();
        rd(32'h14, d, resp);
        chk("coll_rdata_new", 64'(d), 64'h5);

        // Reset between AW and W discards the latched address.
        S_AXI_AWADDR = 32'h18; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        chk("midrst_reg3", 64'(rv(3)), 64'h0);
        S_AXI_WDATA = 32'h66; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        tick(); tick(); tick();
        chk("midrst_no_bvalid", 64'(S_AXI_BVALID), 64'd0);
        chk("midrst_reg6", 64'(rv(6)), 64'h0);
        chk("midrst_awready", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'h2);
        S_AXI_AWADDR = 32'h18; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        tick();
        chk("midrst_commit_bvalid", 64'(S_AXI_BVALID), 64'd1);
        chk("midrst_commit_reg6", 64'(rv(6)), 64'h66);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
